bcd_counter_chain: RTL



---
 rtl/bcd_counter_chain_if.sv | 26 ++
 rtl/bcd_counter_chain.sv | 78 +++++++
 2 files changed

// File: rtl/bcd_counter_chain_if.sv
// Signal bundle for bcd_counter_chain: logic-clock sample, controls, load data and counter outputs.
// The testbench or host drives the master side; the counter is the slave side.
interface bcd_counter_chain_if #(
  parameter int DIGITS = 2
);
  logic                  clk;       // original logic clock, sampled as data
  logic                  clr_n;
  logic                  load_n;
  logic                  enp;
  logic                  ent;
  logic                  up_dn;
  logic [4*DIGITS-1:0]   d;
  logic [4*DIGITS-1:0]   q;
  logic [DIGITS-1:0]     digit_tc;
  logic                  rco;

  modport master (
    output clk, clr_n, load_n, enp, ent, up_dn, d,
    input  q, digit_tc, rco
  );

  modport slave (
    input  clk, clr_n, load_n, enp, ent, up_dn, d,
    output q, digit_tc, rco
  );
endinterface

// File: rtl/bcd_counter_chain.sv
// Cascaded modulo-MOD counter of DIGITS 4-bit stages, stepped on detected rising edges of bus.clk.
// Define BCD_CHAIN_UPDOWN_EN to enable down counting via bus.up_dn; otherwise the block counts up only.
module bcd_counter_chain #(
  parameter int DIGITS = 2,
  parameter int MOD    = 10
) (
  input  logic                   clk_drv,
  input  logic                   rst,
  bcd_counter_chain_if.slave     bus
);

  localparam logic [3:0] TOP = 4'(MOD - 1);

  logic [4*DIGITS-1:0] q;
  logic [4*DIGITS-1:0] q_step;
  logic [DIGITS-1:0]   tc;
  logic                clk_q;
  logic                clk_edge;

`ifndef BCD_CHAIN_UPDOWN_EN
  logic unused_up_dn;
  assign unused_up_dn = bus.up_dn;
`endif

  assign clk_edge = bus.clk & ~clk_q;

  // Per-digit terminal flags and the next value when a count is taken.
  // All digits whose lower neighbours are terminal step together in one cycle.
  always_comb begin
    logic [3:0] digit;
    logic [3:0] nxt;
    logic       term;
    logic       carry;
    // NOTE: every variable gets a default before any conditional use so no latch is inferred.
    q_step = q;
    tc     = '0;
    digit  = '0;
    nxt    = '0;
    term   = 1'b0;
    carry  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      digit = q[4*i +: 4];
      term  = (digit >= TOP);
      nxt   = term ? 4'd0 : digit + 4'd1;
`ifdef BCD_CHAIN_UPDOWN_EN
      if (!bus.up_dn) begin
        term = (digit == 4'd0);
        nxt  = term ? TOP : digit - 4'd1;
      end
`endif
      tc[i] = term;
      if (carry) q_step[4*i +: 4] = nxt;
      carry = carry & term;
    end
  end

  // Reset parks clk_q high so a logic clock already high at release does not count.
  always_ff @(posedge clk_drv) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      q     <= '0;
      clk_q <= 1'b1;
    end else begin
      clk_q <= bus.clk;
      if (!bus.clr_n)
        q <= '0;
      else if (clk_edge && !bus.load_n)
        q <= bus.d;
      else if (clk_edge && bus.enp && bus.ent)
        q <= q_step;
    end
  end

  assign bus.q        = q;
  assign bus.digit_tc = tc;
  assign bus.rco      = bus.ent & (&tc);

endmodule
